// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   SHIFT_* : mode encodings carried on mode_i
//   levels_per_stage : shifter levels placed in each register stage (last stage gets the remainder)
//   min_int : small constant helper used when sizing the per-stage level ranges
package shift_pkg;

   localparam logic [1:0] SHIFT_SLL  = 2'b00;
   localparam logic [1:0] SHIFT_SRL  = 2'b01;
   localparam logic [1:0] SHIFT_SRA  = 2'b10;
   localparam logic [1:0] SHIFT_ROTR = 2'b11;

   function automatic int levels_per_stage(input int nlev, input int stages);
      return (nlev + stages - 1) / stages;
   endfunction

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/shift_unit_pipelined_if.sv
// Handshake/data bundle of the pipelined shifter.
//   slave  : the shifter side (takes the operation, drives the result)
//   master : the producer/consumer side (drives the operation, takes the result)
//   in  path: valid_i, ready_o, data_i, shamt_i, mode_i, tag_i
//   out path: valid_o, ready_i, data_o, tag_o
interface shift_unit_pipelined_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
);
   localparam int SW = $clog2(WIDTH);

   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] data_i;
   logic [SW-1:0]    shamt_i;
   logic [1:0]       mode_i;
   logic [TAG_W-1:0] tag_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] data_o;
   logic [TAG_W-1:0] tag_o;

   modport slave (
      input  valid_i, data_i, shamt_i, mode_i, tag_i, ready_i,
      output ready_o, valid_o, data_o, tag_o
   );

   modport master (
      output valid_i, data_i, shamt_i, mode_i, tag_i, ready_i,
      input  ready_o, valid_o, data_o, tag_o
   );
endinterface

// File: rtl/shift_level.sv
// One combinational level of the barrel shifter: shifts by the fixed distance DIST when
// enabled, in the requested mode.
//   i_data : word entering the level
//   i_en   : shift amount bit for this level
//   i_mode : SLL / SRL / SRA / ROTR
//   i_sign : original operand MSB, used as SRA fill
//   o_data : word leaving the level
module shift_level
   import shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_en,
   input  logic [1:0]       i_mode,
   input  logic             i_sign,
   output logic [WIDTH-1:0] o_data
);

   always_comb begin
      o_data = i_data;
      if (i_en) begin
         case (i_mode)
            SHIFT_SLL:  o_data = {i_data[WIDTH-DIST-1:0], {DIST{1'b0}}};
            SHIFT_SRL:  o_data = {{DIST{1'b0}}, i_data[WIDTH-1:DIST]};
            SHIFT_SRA:  o_data = {{DIST{i_sign}}, i_data[WIDTH-1:DIST]};
            SHIFT_ROTR: o_data = {i_data[DIST-1:0], i_data[WIDTH-1:DIST]};
            default:    o_data = i_data;
         endcase
      end
   end

endmodule

// File: rtl/shift_unit_pipelined.sv
// Pipelined barrel shifter with valid/ready handshake and sideband tag.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : operation in (valid_i/ready_o/data_i/shamt_i/mode_i/tag_i),
//                  result out (valid_o/ready_i/data_o/tag_o)
// Levels run LSB first and are grouped into STAGES register stages. The whole pipe
// advances together or holds together (no bubble collapsing).
module shift_unit_pipelined
   import shift_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2,
   parameter int TAG_W  = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   shift_unit_pipelined_if.slave bus
);

   localparam int NLEV = $clog2(WIDTH);
   localparam int SW   = NLEV;
   localparam int LPS  = levels_per_stage(NLEV, STAGES);

   logic [STAGES-1:0] r_valid;
   logic [WIDTH-1:0]  r_data  [STAGES];
   logic [SW-1:0]     r_shamt [STAGES];
   logic [1:0]        r_mode  [STAGES];
   logic              r_sign  [STAGES];
   logic [TAG_W-1:0]  r_tag   [STAGES];

   logic              w_st_valid [STAGES];
   logic [WIDTH-1:0]  w_st_in    [STAGES];
   logic [WIDTH-1:0]  w_st_out   [STAGES];
   logic [SW-1:0]     w_st_shamt [STAGES];
   logic [1:0]        w_st_mode  [STAGES];
   logic              w_st_sign  [STAGES];
   logic [TAG_W-1:0]  w_st_tag   [STAGES];
   logic [WIDTH-1:0]  w_lvl_in   [NLEV];
   logic [WIDTH-1:0]  w_lvl_out  [NLEV];
   logic              w_advance;

   assign w_advance   = !r_valid[STAGES-1] || bus.ready_i;
   assign bus.ready_o = w_advance;
   assign bus.valid_o = r_valid[STAGES-1];
   assign bus.data_o  = r_data[STAGES-1];
   assign bus.tag_o   = r_tag[STAGES-1];

   generate
      for (genvar s = 0; s < STAGES; s++) begin : g_stage
         if (s == 0) begin : g_src_in
            assign w_st_valid[s] = bus.valid_i;
            assign w_st_in[s]    = bus.data_i;
            assign w_st_shamt[s] = bus.shamt_i;
            assign w_st_mode[s]  = bus.mode_i;
            // SRA fill must be the sign of the original operand, not of partial data
            assign w_st_sign[s]  = bus.data_i[WIDTH-1];
            assign w_st_tag[s]   = bus.tag_i;
         end else begin : g_src_reg
            assign w_st_valid[s] = r_valid[s-1];
            assign w_st_in[s]    = r_data[s-1];
            assign w_st_shamt[s] = r_shamt[s-1];
            assign w_st_mode[s]  = r_mode[s-1];
            assign w_st_sign[s]  = r_sign[s-1];
            assign w_st_tag[s]   = r_tag[s-1];
         end

         // a stage may own no levels when LPS*STAGES overshoots NLEV; it then just registers
         if (s * LPS < NLEV) begin : g_out_lvl
            assign w_st_out[s] = w_lvl_out[min_int(s * LPS + LPS, NLEV) - 1];
         end else begin : g_out_pass
            assign w_st_out[s] = w_st_in[s];
         end
      end

      for (genvar k = 0; k < NLEV; k++) begin : g_level
         localparam int S = k / LPS;
         if (k % LPS == 0) begin : g_head
            assign w_lvl_in[k] = w_st_in[S];
         end else begin : g_chain
            assign w_lvl_in[k] = w_lvl_out[k-1];
         end

         shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
         ) u_level (
            .i_data (w_lvl_in[k]),
            .i_en   (w_st_shamt[S][k]),
            .i_mode (w_st_mode[S]),
            .i_sign (w_st_sign[S]),
            .o_data (w_lvl_out[k])
         );
      end
   endgenerate

   // payload only loads behind a valid bit so bubbles leave data_o/tag_o at their last value
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= '0;
         for (int s = 0; s < STAGES; s++) begin
            r_data[s]  <= '0;
            r_shamt[s] <= '0;
            r_mode[s]  <= '0;
            r_sign[s]  <= 1'b0;
            r_tag[s]   <= '0;
         end
      end else if (w_advance) begin
         for (int s = 0; s < STAGES; s++) begin
            r_valid[s] <= w_st_valid[s];
            if (w_st_valid[s]) begin
               r_data[s]  <= w_st_out[s];
               r_shamt[s] <= w_st_shamt[s];
               r_mode[s]  <= w_st_mode[s];
               r_sign[s]  <= w_st_sign[s];
               r_tag[s]   <= w_st_tag[s];
            end
         end
      end
   end

endmodule

// File: tb/tb_shift_unit_pipelined.sv
module tb_shift_unit_pipelined;

   localparam int W  = 32;
   localparam int TW = 5;

   typedef struct {
      logic [W-1:0]  d;
      logic [TW-1:0] t;
      int            c;
   } item_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   shift_unit_pipelined_if #(.WIDTH(W), .TAG_W(TW)) bus2 ();
   shift_unit_pipelined_if #(.WIDTH(W), .TAG_W(TW)) bus1 ();
   shift_unit_pipelined_if #(.WIDTH(W), .TAG_W(TW)) bus5 ();

   shift_unit_pipelined #(.WIDTH(W), .STAGES(2), .TAG_W(TW)) dut2 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus2));
   shift_unit_pipelined #(.WIDTH(W), .STAGES(1), .TAG_W(TW)) dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus1));
   shift_unit_pipelined #(.WIDTH(W), .STAGES(5), .TAG_W(TW)) dut5 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus5));

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   item_t exp2[$], got2[$], exp1[$], got1[$], exp5[$], got5[$];

   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int s, input logic [1:0] m);
      logic [2*W-1:0] t;
      case (m)
         2'd0:    return d << s;
         2'd1:    return d >> s;
         2'd2:    return W'($signed(d) >>> s);
         default: begin
            t = {d, d} >> s;
            return t[W-1:0];
         end
      endcase
   endfunction

   // cycle bookkeeping: log accepted operations (with their expected result) and delivered results
   task automatic tick();
      #1;
      if (rst_i) begin
         exp2.delete(); exp1.delete(); exp5.delete();
      end else begin
         if (bus2.valid_i && bus2.ready_o)
            exp2.push_back('{d: ref_shift(bus2.data_i, int'(bus2.shamt_i), bus2.mode_i), t: bus2.tag_i, c: cyc});
         if (bus1.valid_i && bus1.ready_o)
            exp1.push_back('{d: ref_shift(bus1.data_i, int'(bus1.shamt_i), bus1.mode_i), t: bus1.tag_i, c: cyc});
         if (bus5.valid_i && bus5.ready_o)
            exp5.push_back('{d: ref_shift(bus5.data_i, int'(bus5.shamt_i), bus5.mode_i), t: bus5.tag_i, c: cyc});
         if (bus2.valid_o && bus2.ready_i) got2.push_back('{d: bus2.data_o, t: bus2.tag_o, c: cyc});
         if (bus1.valid_o && bus1.ready_i) got1.push_back('{d: bus1.data_o, t: bus1.tag_o, c: cyc});
         if (bus5.valid_o && bus5.ready_i) got5.push_back('{d: bus5.data_o, t: bus5.tag_o, c: cyc});
      end
      @(posedge clk_i);
      cyc++;
      #1;
   endtask

   task automatic clear_q();
      exp2.delete(); got2.delete(); exp1.delete(); got1.delete(); exp5.delete(); got5.delete();
   endtask

   task automatic drive2(input logic v, input logic [W-1:0] d, input logic [4:0] s,
                         input logic [1:0] m, input logic [TW-1:0] t);
      bus2.valid_i = v; bus2.data_i = d; bus2.shamt_i = s; bus2.mode_i = m; bus2.tag_i = t;
   endtask

   task automatic drive2_rand();
      drive2(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), TW'($urandom_range(0, 31)));
   endtask

   task automatic test_reset();
      bus2.valid_i = 0; bus1.valid_i = 0; bus5.valid_i = 0;
      bus2.ready_i = 0; bus1.ready_i = 0; bus5.ready_i = 0;
      drive2(1'b0, '0, '0, '0, '0);
      rst_i = 1;
      tick(); tick();
      rst_i = 0;
      #1;
      n_checks++; if (bus2.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o got %b want 0", bus2.valid_o); end
      n_checks++; if (bus2.data_o !== '0) begin n_fail++; $display("FAIL reset_data_o got %h want 0", bus2.data_o); end
      n_checks++; if (bus2.tag_o !== '0) begin n_fail++; $display("FAIL reset_tag_o got %h want 0", bus2.tag_o); end
      n_checks++; if (bus2.ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready_o got %b want 1", bus2.ready_o); end
      n_checks++; if (bus5.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid_o_s5 got %b want 0", bus5.valid_o); end
      bus2.ready_i = 1; bus1.ready_i = 1; bus5.ready_i = 1;
   endtask

   task automatic test_directed();
      logic [W-1:0] din  [4] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_000F};
      logic [4:0]   sh   [4] = '{5'd2, 5'd31, 5'd4, 5'd4};
      logic [1:0]   md   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
      logic [W-1:0] want [4] = '{32'h0000_0004, 32'h0000_0001, 32'hF800_0000, 32'hF000_0000};
      clear_q();
      for (int i = 0; i < 4; i++) begin
         drive2(1'b1, din[i], sh[i], md[i], TW'(i + 1));
         tick();
      end
      bus2.valid_i = 0;
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (got2.size() != 4) begin n_fail++; $display("FAIL directed_count got %0d want 4", got2.size()); end
      for (int i = 0; i < 4 && i < got2.size() && i < exp2.size(); i++) begin
         n_checks++; if (got2[i].d !== want[i]) begin n_fail++; $display("FAIL directed_data[%0d] got %h want %h", i, got2[i].d, want[i]); end
         n_checks++; if (got2[i].t !== TW'(i + 1)) begin n_fail++; $display("FAIL directed_tag[%0d] got %0d want %0d", i, got2[i].t, i + 1); end
         n_checks++; if (got2[i].c - exp2[i].c != 2) begin n_fail++; $display("FAIL directed_latency[%0d] got %0d want 2", i, got2[i].c - exp2[i].c); end
      end
   endtask

   task automatic test_shamt0();
      clear_q();
      for (int m = 0; m < 4; m++) begin
         drive2(1'b1, 32'hDEAD_BEEF, 5'd0, 2'(m), TW'(m + 10));
         tick();
      end
      bus2.valid_i = 0;
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (got2.size() != 4) begin n_fail++; $display("FAIL shamt0_count got %0d want 4", got2.size()); end
      for (int i = 0; i < got2.size() && i < 4; i++) begin
         n_checks++; if (got2[i].d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL shamt0_data[mode %0d] got %h want deadbeef", i, got2[i].d); end
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0]  snap_d;
      logic [TW-1:0] snap_t;
      clear_q();
      for (int i = 0; i < 2; i++) begin
         drive2_rand();
         tick();
      end
      drive2_rand();
      bus2.ready_i = 0;
      #1;
      snap_d = bus2.data_o;
      snap_t = bus2.tag_o;
      n_checks++; if (bus2.valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_full_valid got %b want 1", bus2.valid_o); end
      for (int i = 0; i < 5; i++) begin
         n_checks++; if (bus2.ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_o[%0d] got %b want 0", i, bus2.ready_o); end
         n_checks++; if (bus2.data_o !== snap_d) begin n_fail++; $display("FAIL bp_data_stable[%0d] got %h want %h", i, bus2.data_o, snap_d); end
         n_checks++; if (bus2.tag_o !== snap_t) begin n_fail++; $display("FAIL bp_tag_stable[%0d] got %0d want %0d", i, bus2.tag_o, snap_t); end
         tick();
      end
      bus2.ready_i = 1;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) drive2_rand();
         tick();
      end
      bus2.valid_i = 0;
      for (int i = 0; i < 5; i++) tick();
      n_checks++; if (got2.size() != 6) begin n_fail++; $display("FAIL bp_count got %0d want 6", got2.size()); end
      for (int i = 0; i < got2.size() && i < exp2.size(); i++) begin
         n_checks++;
         if (got2[i].d !== exp2[i].d || got2[i].t !== exp2[i].t) begin
            n_fail++; $display("FAIL bp_order[%0d] got %h/%0d want %h/%0d", i, got2[i].d, got2[i].t, exp2[i].d, exp2[i].t);
         end
      end
   endtask

   task automatic test_bubbles();
      logic pat [3] = '{1'b1, 1'b0, 1'b1};
      clear_q();
      for (int i = 0; i < 3; i++) begin
         drive2_rand();
         bus2.valid_i = pat[i];
         tick();
      end
      bus2.valid_i = 0;
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (got2.size() != 2) begin n_fail++; $display("FAIL bubble_count got %0d want 2", got2.size()); end
      if (got2.size() == 2 && exp2.size() == 2) begin
         n_checks++; if (got2[0].c - exp2[0].c != 2) begin n_fail++; $display("FAIL bubble_latency got %0d want 2", got2[0].c - exp2[0].c); end
         n_checks++; if (got2[1].c - got2[0].c != 2) begin n_fail++; $display("FAIL bubble_gap got %0d want 2", got2[1].c - got2[0].c); end
      end
   endtask

   task automatic test_reset_midflight();
      clear_q();
      drive2(1'b1, 32'hA5A5_A5A5, 5'd0, 2'b00, 5'd7);
      tick();
      drive2(1'b1, 32'h5A5A_5A5A, 5'd0, 2'b00, 5'd9);
      tick();
      drive2(1'b1, 32'h1234_5678, 5'd0, 2'b00, 5'd3);
      rst_i = 1;
      tick();
      rst_i = 0;
      bus2.valid_i = 0;
      #1;
      n_checks++; if (bus2.valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus2.valid_o); end
      n_checks++; if (bus2.data_o !== '0) begin n_fail++; $display("FAIL midrst_data got %h want 0", bus2.data_o); end
      n_checks++; if (bus2.tag_o !== '0) begin n_fail++; $display("FAIL midrst_tag got %0d want 0", bus2.tag_o); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (bus2.valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_stale[%0d] got %b want 0", i, bus2.valid_o); end
      end
      n_checks++; if (got2.size() != 0) begin n_fail++; $display("FAIL midrst_results got %0d want 0", got2.size()); end
   endtask

   task automatic test_sweep();
      clear_q();
      for (int i = 0; i < 300; i++) begin
         drive2_rand();
         bus2.valid_i = ($urandom_range(0, 3) != 0);
         bus2.ready_i = ($urandom_range(0, 3) != 0);
         bus1.valid_i = ($urandom_range(0, 3) != 0);
         bus1.data_i = $urandom; bus1.shamt_i = 5'($urandom_range(0, 31));
         bus1.mode_i = 2'($urandom_range(0, 3)); bus1.tag_i = TW'($urandom_range(0, 31));
         bus5.valid_i = ($urandom_range(0, 3) != 0);
         bus5.data_i = $urandom; bus5.shamt_i = 5'($urandom_range(0, 31));
         bus5.mode_i = 2'($urandom_range(0, 3)); bus5.tag_i = TW'($urandom_range(0, 31));
         tick();
      end
      bus2.valid_i = 0; bus1.valid_i = 0; bus5.valid_i = 0;
      bus2.ready_i = 1;
      for (int i = 0; i < 10; i++) tick();
      n_checks++; if (got2.size() != exp2.size()) begin n_fail++; $display("FAIL sweep2_count got %0d want %0d", got2.size(), exp2.size()); end
      n_checks++; if (got1.size() != exp1.size()) begin n_fail++; $display("FAIL sweep1_count got %0d want %0d", got1.size(), exp1.size()); end
      n_checks++; if (got5.size() != exp5.size()) begin n_fail++; $display("FAIL sweep5_count got %0d want %0d", got5.size(), exp5.size()); end
      for (int i = 0; i < got2.size() && i < exp2.size(); i++) begin
         n_checks++;
         if (got2[i].d !== exp2[i].d || got2[i].t !== exp2[i].t) begin
            n_fail++; $display("FAIL sweep2[%0d] got %h/%0d want %h/%0d", i, got2[i].d, got2[i].t, exp2[i].d, exp2[i].t);
         end
      end
      for (int i = 0; i < got1.size() && i < exp1.size(); i++) begin
         n_checks++;
         if (got1[i].d !== exp1[i].d || got1[i].t !== exp1[i].t || got1[i].c - exp1[i].c != 1) begin
            n_fail++; $display("FAIL sweep1[%0d] got %h/%0d lat %0d want %h/%0d lat 1", i, got1[i].d, got1[i].t, got1[i].c - exp1[i].c, exp1[i].d, exp1[i].t);
         end
      end
      for (int i = 0; i < got5.size() && i < exp5.size(); i++) begin
         n_checks++;
         if (got5[i].d !== exp5[i].d || got5[i].t !== exp5[i].t || got5[i].c - exp5[i].c != 5) begin
            n_fail++; $display("FAIL sweep5[%0d] got %h/%0d lat %0d want %h/%0d lat 5", i, got5[i].d, got5[i].t, got5[i].c - exp5[i].c, exp5[i].d, exp5[i].t);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_shamt0();
      test_backpressure();
      test_bubbles();
      test_reset_midflight();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
